// File: rtl/store_buffer_pkg.sv
// Shared defaults, entry layout and FSM states for the store buffer.
// Forwarding is optional and enabled with the STORE_BUFFER_FWD_EN macro.
package store_buffer_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DEPTH      = 4;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_WIDTH-1:0]      data;
    } sb_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_fifo_ctrl.sv
// Circular FIFO bookkeeping for the store buffer: head/tail pointers,
// occupancy count and full/empty flags.
module sb_fifo_ctrl
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= (tail == LAST) ? '0 : tail + PTR_W'(1);
            end
            if (pop) begin
                head <= (head == LAST) ? '0 : head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues CPU stores and drains them to data memory in order.
// Define STORE_BUFFER_FWD_EN to build store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         St_Valid,
    input  logic [ADDR_WIDTH-1:0]        St_Addr,
    input  logic [WIDTH-1:0]             St_Data,
    output logic                         St_Ready,
    input  logic                         Flush,
    output logic                         Flush_Done,
    input  logic [ADDR_WIDTH-1:0]        Ld_Addr,
    output logic                         Ld_Hit,
    output logic [WIDTH-1:0]             Ld_Data,
    output logic [ADDR_WIDTH-1:0]        Mem_A,
    output logic [WIDTH-1:0]             Mem_WD,
    output logic                         Mem_WE,
    input  logic                         Mem_Stall,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Same {addr, data} layout as sb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    sb_state_e         state;
    sb_state_e         state_next;

    assign St_Ready = !full && (state == RUN);
    assign push     = St_Valid && St_Ready;
    assign Mem_WE   = !empty && !Mem_Stall;
    assign pop      = Mem_WE;
    assign Mem_A    = empty ? '0 : entries[head].addr;
    assign Mem_WD   = empty ? '0 : entries[head].data;
    assign Count    = count;
    assign Empty    = empty;

    sb_fifo_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_fifo_ctrl (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .head  (head),
        .tail  (tail),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push) begin
            entries[tail] <= '{addr: St_Addr, data: St_Data};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Flush_Done marks the last DRAIN cycle, i.e. the one that returns to RUN.
    always_comb begin
        state_next = state;
        Flush_Done = 1'b0;
        case (state)
            RUN: begin
                if (Flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_next = RUN;
                    Flush_Done = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        Ld_Hit  = 1'b0;
        Ld_Data = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[fwd_idx].addr == Ld_Addr)) begin
                Ld_Hit  = 1'b1;
                Ld_Data = entries[fwd_idx].data;
            end
        end
    end
`else
    logic unused_ld_addr;

    assign unused_ld_addr = ^Ld_Addr;
    assign Ld_Hit         = 1'b0;
    assign Ld_Data        = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_store_buffer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic           St_Valid;
    logic [AW-1:0]  St_Addr;
    logic [DW-1:0]  St_Data;
    logic           St_Ready;
    logic           Flush;
    logic           Flush_Done;
    logic [AW-1:0]  Ld_Addr;
    logic           Ld_Hit;
    logic [DW-1:0]  Ld_Data;
    logic [AW-1:0]  Mem_A;
    logic [DW-1:0]  Mem_WD;
    logic           Mem_WE;
    logic           Mem_Stall;
    logic [2:0]     Count;
    logic           Empty;

    int errCount   = 0;
    int checkCount = 0;

    always #5 CLK = ~CLK;

    store_buffer #(
        .ADDR_WIDTH (AW),
        .WIDTH      (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .St_Valid   (St_Valid),
        .St_Addr    (St_Addr),
        .St_Data    (St_Data),
        .St_Ready   (St_Ready),
        .Flush      (Flush),
        .Flush_Done (Flush_Done),
        .Ld_Addr    (Ld_Addr),
        .Ld_Hit     (Ld_Hit),
        .Ld_Data    (Ld_Data),
        .Mem_A      (Mem_A),
        .Mem_WD     (Mem_WD),
        .Mem_WE     (Mem_WE),
        .Mem_Stall  (Mem_Stall),
        .Count      (Count),
        .Empty      (Empty)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic valid, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic flush, input logic stall,
                                 input logic [AW-1:0] ld);
        @(posedge CLK);
        #1;
        RST       = rst;
        St_Valid  = valid;
        St_Addr   = addr;
        St_Data   = data;
        Flush     = flush;
        Mem_Stall = stall;
        Ld_Addr   = ld;
        #1;
    endtask

    task automatic pushStore(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic stall);
        applyStimulus(1'b1, 1'b1, addr, data, 1'b0, stall, '0);
    endtask

    task automatic idle(input logic stall);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, stall, '0);
    endtask

    // Reference model: an ordered queue of pending stores and a drain flag.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          model[$];
    bit            modelLive  = 1'b0;
    bit            modelDrain = 1'b0;
    bit            mEmpty;
    bit            mHit;
    logic [DW-1:0] mLdData;
    bit            doPush;
    bit            doPop;
    bit            nextDrain;

    always @(negedge CLK) begin
        if (modelLive) begin
            mEmpty  = (model.size() == 0);
            mHit    = 1'b0;
            mLdData = '0;
`ifdef STORE_BUFFER_FWD_EN
            for (int i = model.size() - 1; i >= 0; i--) begin
                if (!mHit && model[i].a == Ld_Addr) begin
                    mHit    = 1'b1;
                    mLdData = model[i].d;
                end
            end
`endif
            checkOutput("m_count",    Count, model.size());
            checkOutput("m_empty",    Empty, mEmpty);
            checkOutput("m_st_ready", St_Ready, (model.size() < DEPTH) && !modelDrain);
            checkOutput("m_mem_we",   Mem_WE, !mEmpty && !Mem_Stall);
            checkOutput("m_mem_a",    Mem_A,  mEmpty ? '0 : model[0].a);
            checkOutput("m_mem_wd",   Mem_WD, mEmpty ? '0 : model[0].d);
            checkOutput("m_flush_dn", Flush_Done, modelDrain && mEmpty);
            checkOutput("m_ld_hit",   Ld_Hit, mHit);
            checkOutput("m_ld_data",  Ld_Data, mLdData);
        end
        if (RST === 1'b0) begin
            model.delete();
            modelDrain = 1'b0;
            modelLive  = 1'b1;
        end else if (modelLive) begin
            doPush    = St_Valid && (model.size() < DEPTH) && !modelDrain;
            doPop     = (model.size() != 0) && !Mem_Stall;
            nextDrain = modelDrain ? (model.size() != 0) : Flush;
            if (doPop) begin
                void'(model.pop_front());
            end
            if (doPush) begin
                model.push_back('{a: St_Addr, d: St_Data});
            end
            modelDrain = nextDrain;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST       = 1'b0;
        St_Valid  = 1'b0;
        St_Addr   = '0;
        St_Data   = '0;
        Flush     = 1'b0;
        Mem_Stall = 1'b0;
        Ld_Addr   = '0;

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        $display("[TB] reset state");
        checkOutput("rst_empty",    Empty, 1);
        checkOutput("rst_count",    Count, 0);
        checkOutput("rst_st_ready", St_Ready, 1);
        checkOutput("rst_mem_we",   Mem_WE, 0);
        checkOutput("rst_ld_hit",   Ld_Hit, 0);
        checkOutput("rst_flush_dn", Flush_Done, 0);

        $display("[TB] single store latency");
        pushStore(32'h4, 32'hAA, 1'b0);
        checkOutput("lat_we_same_cycle", Mem_WE, 0);
        idle(1'b0);
        checkOutput("lat_we",    Mem_WE, 1);
        checkOutput("lat_mem_a", Mem_A, 32'h4);
        checkOutput("lat_mem_wd", Mem_WD, 32'hAA);
        idle(1'b0);
        checkOutput("lat_empty_after", Empty, 1);

        $display("[TB] fill under stall");
        for (int i = 0; i < 4; i++) begin
            pushStore(32'h10 + i, 32'h100 + i, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 32'h50, 32'h500, 1'b0, 1'b1, '0);
        checkOutput("full_count", Count, 4);
        checkOutput("full_ready", St_Ready, 0);
        checkOutput("full_we",    Mem_WE, 0);
        idle(1'b0);
        checkOutput("full_count_after_5th", Count, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_mem_a",  Mem_A, 32'h10 + i);
            checkOutput("drain_mem_wd", Mem_WD, 32'h100 + i);
            idle(1'b0);
        end
        checkOutput("drain_empty", Empty, 1);

        $display("[TB] forwarding");
        pushStore(32'h8, 32'h11, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h8, 32'h22, 1'b0, 1'b1, 32'h8);
`ifdef STORE_BUFFER_FWD_EN
        checkOutput("fwd_old_hit",  Ld_Hit, 1);
        checkOutput("fwd_old_data", Ld_Data, 32'h11);
`else
        checkOutput("fwd_old_hit",  Ld_Hit, 0);
        checkOutput("fwd_old_data", Ld_Data, 0);
`endif
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 32'h8);
`ifdef STORE_BUFFER_FWD_EN
        checkOutput("fwd_young_hit",  Ld_Hit, 1);
        checkOutput("fwd_young_data", Ld_Data, 32'h22);
`else
        checkOutput("fwd_young_hit",  Ld_Hit, 0);
        checkOutput("fwd_young_data", Ld_Data, 0);
`endif
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 32'hC);
        checkOutput("fwd_miss_hit",  Ld_Hit, 0);
        checkOutput("fwd_miss_data", Ld_Data, 0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("fwd_drained", Empty, 1);

        $display("[TB] full with simultaneous pop, then wrap");
        for (int i = 0; i < 4; i++) begin
            pushStore(32'h60 + i, 32'h600 + i, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 32'h99, 32'h999, 1'b0, 1'b0, '0);
        checkOutput("pp_ready", St_Ready, 0);
        checkOutput("pp_we",    Mem_WE, 1);
        checkOutput("pp_mem_a", Mem_A, 32'h60);
        idle(1'b0);
        checkOutput("pp_count", Count, 3);
        checkOutput("pp_next_a", Mem_A, 32'h61);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("pp_empty", Empty, 1);
        for (int i = 0; i < 10; i++) begin
            pushStore(32'h200 + 4 * i, 32'h2000 + i, 1'b0);
            if (i > 0) begin
                checkOutput("wrap_mem_a", Mem_A, 32'h200 + 4 * (i - 1));
                checkOutput("wrap_count", Count, 1);
            end
        end
        idle(1'b0);
        checkOutput("wrap_last_a",  Mem_A, 32'h224);
        checkOutput("wrap_last_wd", Mem_WD, 32'h2009);
        idle(1'b0);
        checkOutput("wrap_empty", Empty, 1);

        $display("[TB] flush with three entries");
        for (int i = 0; i < 3; i++) begin
            pushStore(32'h30 + i, 32'h300 + i, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        checkOutput("fl_ready_run", St_Ready, 1);
        checkOutput("fl_mem_a",     Mem_A, 32'h30);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 1'b0, '0, '0, (c >= 2), 1'b0, '0);
            checkOutput("fl_ready_drain", St_Ready, 0);
            checkOutput("fl_done",        Flush_Done, (c == 3));
        end
        idle(1'b0);
        checkOutput("fl_ready_back", St_Ready, 1);
        checkOutput("fl_done_off",   Flush_Done, 0);

        $display("[TB] flush with empty buffer");
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        checkOutput("efl_ready0", St_Ready, 1);
        idle(1'b0);
        checkOutput("efl_ready1", St_Ready, 0);
        checkOutput("efl_done1",  Flush_Done, 1);
        idle(1'b0);
        checkOutput("efl_ready2", St_Ready, 1);
        checkOutput("efl_done2",  Flush_Done, 0);

        $display("[TB] reset mid-drain");
        for (int i = 0; i < 3; i++) begin
            pushStore(32'h70 + i, 32'h700 + i, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        idle(1'b0);
        checkOutput("rd_count_before", Count, 2);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        idle(1'b0);
        checkOutput("rd_count", Count, 0);
        checkOutput("rd_we",    Mem_WE, 0);
        checkOutput("rd_empty", Empty, 1);
        checkOutput("rd_ready", St_Ready, 1);
        idle(1'b0);
        idle(1'b0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
